// File: rtl/pipelined_decode_stage.sv
// Decode stage: register file with write-through bypass, immediate extension,
// load-use hazard detection and the ID/EX pipeline register.
module pipelined_decode_stage #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 5,
  parameter int STALL_CNT_WIDTH = 16
) (
  input  logic                       Clk,
  input  logic                       Rst,
  input  logic [31:0]                Instruction,
  input  logic                       InValid,
  input  logic [DATA_WIDTH-1:0]      PCAddResult,
  input  logic                       ZeroExt,
  input  logic                       RegWrite,
  input  logic [ADDR_WIDTH-1:0]      WriteRegister,
  input  logic [DATA_WIDTH-1:0]      WriteData,
  input  logic                       EX_MemRead,
  input  logic [ADDR_WIDTH-1:0]      EX_Rt,
  input  logic                       Flush,
  input  logic                       Hold,
  output logic                       Stall,
  output logic [DATA_WIDTH-1:0]      ReadData1_q,
  output logic [DATA_WIDTH-1:0]      ReadData2_q,
  output logic [DATA_WIDTH-1:0]      Imm_q,
  output logic [ADDR_WIDTH-1:0]      Rs_q,
  output logic [ADDR_WIDTH-1:0]      Rt_q,
  output logic [ADDR_WIDTH-1:0]      Rd_q,
  output logic [DATA_WIDTH-1:0]      PCAddResult_q,
  output logic                       Valid_q,
  output logic [STALL_CNT_WIDTH-1:0] StallCount
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0]      regs_q [DEPTH];
  logic [DATA_WIDTH-1:0]      regs_d [DEPTH];
  logic [ADDR_WIDTH-1:0]      rs, rt, rd;
  logic [15:0]                imm;
  logic                       wr_en;
  logic [DATA_WIDTH-1:0]      read_data1, read_data2, imm_ext;
  logic [DATA_WIDTH-1:0]      read_data1_d, read_data2_d, imm_d, pc_add_result_d;
  logic [ADDR_WIDTH-1:0]      rs_d, rt_d, rd_d;
  logic                       valid_d;
  logic [STALL_CNT_WIDTH-1:0] stall_count_q, stall_count_d;
  logic                       unused_instr_bits;

  assign rs    = Instruction[21 +: ADDR_WIDTH];
  assign rt    = Instruction[16 +: ADDR_WIDTH];
  assign rd    = Instruction[11 +: ADDR_WIDTH];
  assign imm   = Instruction[15:0];
  assign wr_en = RegWrite && (WriteRegister != '0);

  // Opcode/funct bits and high specifier bits are decoded further downstream.
  assign unused_instr_bits = ^Instruction;

  assign StallCount = stall_count_q;

  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[WriteRegister] = WriteData;
    end
  end

  // A writeback landing this cycle is forwarded so ID never reads a stale value.
  always_comb begin
    read_data1 = '0;
    read_data2 = '0;
    if (wr_en && (WriteRegister == rs)) begin
      read_data1 = WriteData;
    end else if (rs != '0) begin
      read_data1 = regs_q[rs];
    end
    if (wr_en && (WriteRegister == rt)) begin
      read_data2 = WriteData;
    end else if (rt != '0) begin
      read_data2 = regs_q[rt];
    end
  end

  always_comb begin
    if (ZeroExt) begin
      imm_ext = DATA_WIDTH'(imm);
    end else begin
      imm_ext = DATA_WIDTH'($signed(imm));
    end
  end

  assign Stall = InValid && EX_MemRead && (EX_Rt != '0) &&
                 ((EX_Rt == rs) || (EX_Rt == rt)) && !Hold && !Flush;

  always_comb begin
    read_data1_d    = ReadData1_q;
    read_data2_d    = ReadData2_q;
    imm_d           = Imm_q;
    rs_d            = Rs_q;
    rt_d            = Rt_q;
    rd_d            = Rd_q;
    pc_add_result_d = PCAddResult_q;
    valid_d         = Valid_q;
    if (!Hold) begin
      if (Flush || Stall || !InValid) begin
        read_data1_d    = '0;
        read_data2_d    = '0;
        imm_d           = '0;
        rs_d            = '0;
        rt_d            = '0;
        rd_d            = '0;
        pc_add_result_d = '0;
        valid_d         = 1'b0;
      end else begin
        read_data1_d    = read_data1;
        read_data2_d    = read_data2;
        imm_d           = imm_ext;
        rs_d            = rs;
        rt_d            = rt;
        rd_d            = rd;
        pc_add_result_d = PCAddResult;
        valid_d         = 1'b1;
      end
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (Stall && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      ReadData1_q   <= '0;
      ReadData2_q   <= '0;
      Imm_q         <= '0;
      Rs_q          <= '0;
      Rt_q          <= '0;
      Rd_q          <= '0;
      PCAddResult_q <= '0;
      Valid_q       <= 1'b0;
      stall_count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
      ReadData1_q   <= read_data1_d;
      ReadData2_q   <= read_data2_d;
      Imm_q         <= imm_d;
      Rs_q          <= rs_d;
      Rt_q          <= rt_d;
      Rd_q          <= rd_d;
      PCAddResult_q <= pc_add_result_d;
      Valid_q       <= valid_d;
      stall_count_q <= stall_count_d;
    end
  end

endmodule

// File: tb/tb_pipelined_decode_stage.sv
// Bench for pipelined_decode_stage: a default instance and a narrow
// (16-bit data, 3-bit specifier, 2-bit counter) instance share one stimulus stream.
module tb_pipelined_decode_stage;

  logic        Clk;
  logic        Rst;
  logic [31:0] Instruction;
  logic        InValid;
  logic [31:0] PCAddResult;
  logic        ZeroExt;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic        EX_MemRead;
  logic [4:0]  EX_Rt;
  logic        Flush;
  logic        Hold;

  logic        Stall;
  logic [31:0] ReadData1_q, ReadData2_q, Imm_q, PCAddResult_q;
  logic [4:0]  Rs_q, Rt_q, Rd_q;
  logic        Valid_q;
  logic [15:0] StallCount;

  logic        s_stall;
  logic [15:0] s_rd1, s_rd2, s_imm, s_pc;
  logic [2:0]  s_rs, s_rt, s_rd;
  logic        s_valid;
  logic [1:0]  s_cnt;

  int vectors = 0;
  int miscompares = 0;

  pipelined_decode_stage dut (
    .Clk(Clk), .Rst(Rst), .Instruction(Instruction), .InValid(InValid),
    .PCAddResult(PCAddResult), .ZeroExt(ZeroExt), .RegWrite(RegWrite),
    .WriteRegister(WriteRegister), .WriteData(WriteData), .EX_MemRead(EX_MemRead),
    .EX_Rt(EX_Rt), .Flush(Flush), .Hold(Hold), .Stall(Stall),
    .ReadData1_q(ReadData1_q), .ReadData2_q(ReadData2_q), .Imm_q(Imm_q),
    .Rs_q(Rs_q), .Rt_q(Rt_q), .Rd_q(Rd_q), .PCAddResult_q(PCAddResult_q),
    .Valid_q(Valid_q), .StallCount(StallCount)
  );

  pipelined_decode_stage #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .STALL_CNT_WIDTH(2)) dut_small (
    .Clk(Clk), .Rst(Rst), .Instruction(Instruction), .InValid(InValid),
    .PCAddResult(PCAddResult[15:0]), .ZeroExt(ZeroExt), .RegWrite(RegWrite),
    .WriteRegister(WriteRegister[2:0]), .WriteData(WriteData[15:0]),
    .EX_MemRead(EX_MemRead), .EX_Rt(EX_Rt[2:0]), .Flush(Flush), .Hold(Hold),
    .Stall(s_stall), .ReadData1_q(s_rd1), .ReadData2_q(s_rd2), .Imm_q(s_imm),
    .Rs_q(s_rs), .Rt_q(s_rt), .Rd_q(s_rd), .PCAddResult_q(s_pc),
    .Valid_q(s_valid), .StallCount(s_cnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference model: index 0 = default instance, index 1 = narrow instance.
  logic [31:0] amask [2] = '{32'h1f, 32'h07};
  logic [31:0] dmask [2] = '{32'hffff_ffff, 32'h0000_ffff};
  int          cmax  [2] = '{65535, 3};
  logic [31:0] m_regs [2][32];
  logic [31:0] m_rd1 [2], m_rd2 [2], m_imm [2], m_pc [2];
  logic [31:0] m_rs [2], m_rt [2], m_rd [2];
  logic        m_valid [2];
  int          m_cnt [2];

  typedef struct {
    logic        rst, inval, zext, rw;
    logic [4:0]  wr;
    logic [31:0] wdata;
    logic        exmr;
    logic [4:0]  exrt;
    logic        flush, hold;
    logic [31:0] instr;
    logic        exp_stall, exp_valid;
    logic [4:0]  exp_rs, exp_rt;
    logic [31:0] exp_imm, exp_rd1, exp_rd2;
    int          exp_cnt;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic model_stall(input int k);
    logic [31:0] rs, rt, ex;
    rs = (Instruction >> 21) & amask[k];
    rt = (Instruction >> 16) & amask[k];
    ex = {27'h0, EX_Rt} & amask[k];
    return InValid && EX_MemRead && (ex != 0) && ((ex == rs) || (ex == rt)) && !Hold && !Flush;
  endfunction

  function automatic logic [31:0] model_read(input int k, input logic [31:0] r);
    logic [31:0] wr;
    wr = {27'h0, WriteRegister} & amask[k];
    if (RegWrite && (wr != 0) && (wr == r)) return WriteData & dmask[k];
    if (r == 0) return 32'h0;
    return m_regs[k][r];
  endfunction

  task automatic modelEdge();
    logic        st;
    logic [31:0] rs, rt, wr, ext;
    for (int k = 0; k < 2; k++) begin
      st = model_stall(k);
      rs = (Instruction >> 21) & amask[k];
      rt = (Instruction >> 16) & amask[k];
      wr = {27'h0, WriteRegister} & amask[k];
      if (ZeroExt) ext = {16'h0, Instruction[15:0]};
      else         ext = {{16{Instruction[15]}}, Instruction[15:0]};
      if (Rst) begin
        for (int r = 0; r < 32; r++) m_regs[k][r] = 32'h0;
        m_rd1[k] = 0; m_rd2[k] = 0; m_imm[k] = 0; m_pc[k] = 0;
        m_rs[k] = 0; m_rt[k] = 0; m_rd[k] = 0; m_valid[k] = 0; m_cnt[k] = 0;
      end else begin
        if (!Hold) begin
          if (Flush || st || !InValid) begin
            m_rd1[k] = 0; m_rd2[k] = 0; m_imm[k] = 0; m_pc[k] = 0;
            m_rs[k] = 0; m_rt[k] = 0; m_rd[k] = 0; m_valid[k] = 0;
          end else begin
            m_rd1[k]   = model_read(k, rs);
            m_rd2[k]   = model_read(k, rt);
            m_imm[k]   = ext & dmask[k];
            m_pc[k]    = PCAddResult & dmask[k];
            m_rs[k]    = rs;
            m_rt[k]    = rt;
            m_rd[k]    = (Instruction >> 11) & amask[k];
            m_valid[k] = 1'b1;
          end
        end
        if (st && (m_cnt[k] < cmax[k])) m_cnt[k]++;
        if (RegWrite && (wr != 0)) m_regs[k][wr] = WriteData & dmask[k];
      end
    end
  endtask

  task automatic checkOutput();
    check("rd1",     ReadData1_q,            m_rd1[0]);
    check("rd2",     ReadData2_q,            m_rd2[0]);
    check("imm",     Imm_q,                  m_imm[0]);
    check("pc",      PCAddResult_q,          m_pc[0]);
    check("rs",      {27'h0, Rs_q},          m_rs[0]);
    check("rt",      {27'h0, Rt_q},          m_rt[0]);
    check("rd",      {27'h0, Rd_q},          m_rd[0]);
    check("valid",   {31'h0, Valid_q},       {31'h0, m_valid[0]});
    check("cnt",     {16'h0, StallCount},    32'(m_cnt[0]));
    check("s_rd1",   {16'h0, s_rd1},         m_rd1[1]);
    check("s_rd2",   {16'h0, s_rd2},         m_rd2[1]);
    check("s_imm",   {16'h0, s_imm},         m_imm[1]);
    check("s_pc",    {16'h0, s_pc},          m_pc[1]);
    check("s_rs",    {29'h0, s_rs},          m_rs[1]);
    check("s_rt",    {29'h0, s_rt},          m_rt[1]);
    check("s_rd",    {29'h0, s_rd},          m_rd[1]);
    check("s_valid", {31'h0, s_valid},       {31'h0, m_valid[1]});
    check("s_cnt",   {30'h0, s_cnt},         32'(m_cnt[1]));
  endtask

  task automatic applyStimulus(input vec_t v, input logic [31:0] pc, output logic stall_seen);
    @(negedge Clk);
    Rst = v.rst; InValid = v.inval; ZeroExt = v.zext; RegWrite = v.rw;
    WriteRegister = v.wr; WriteData = v.wdata; EX_MemRead = v.exmr; EX_Rt = v.exrt;
    Flush = v.flush; Hold = v.hold; Instruction = v.instr; PCAddResult = pc;
    #1;
    stall_seen = Stall;
    check("stall",   {31'h0, Stall},   {31'h0, model_stall(0)});
    check("s_stall", {31'h0, s_stall}, {31'h0, model_stall(1)});
    @(posedge Clk);
    modelEdge();
    #1;
    checkOutput();
  endtask

  initial begin
    vec_t        v;
    logic        st;
    logic [31:0] r;

    Rst = 1'b0; InValid = 1'b0; ZeroExt = 1'b0; RegWrite = 1'b0; WriteRegister = '0;
    WriteData = '0; EX_MemRead = 1'b0; EX_Rt = '0; Flush = 1'b0; Hold = 1'b0;
    Instruction = '0; PCAddResult = '0;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 32; i++) m_regs[k][i] = 32'h0;
      m_rd1[k] = 0; m_rd2[k] = 0; m_imm[k] = 0; m_pc[k] = 0;
      m_rs[k] = 0; m_rt[k] = 0; m_rd[k] = 0; m_valid[k] = 0; m_cnt[k] = 0;
    end

    //           rst in zx rw wr wdata          mr rt fl ho instr           st va rs rt imm            rd1 rd2 cnt
    vecs[0]  = '{1, 0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 32'h0,         0,  0,  0};
    vecs[1]  = '{0, 1, 0, 0, 0, 32'h0,          0, 0, 0, 0, 32'h20080005,   0, 1, 0, 8, 32'h5,         0,  0,  0};
    vecs[2]  = '{0, 1, 0, 1, 8, 32'h5,          0, 0, 0, 0, 32'h01095020,   0, 1, 8, 9, 32'h5020,      5,  0,  0};
    vecs[3]  = '{0, 1, 0, 1, 0, 32'hdeadbeef,   0, 0, 0, 0, 32'h20080005,   0, 1, 0, 8, 32'h5,         0,  5,  0};
    vecs[4]  = '{0, 1, 0, 0, 0, 32'h0,          0, 0, 0, 0, 32'h00085020,   0, 1, 0, 8, 32'h5020,      0,  5,  0};
    vecs[5]  = '{0, 1, 1, 0, 0, 32'h0,          0, 0, 0, 0, 32'h3b39ffff,   0, 1, 25, 25, 32'h0000ffff, 0, 0,  0};
    vecs[6]  = '{0, 1, 0, 0, 0, 32'h0,          0, 0, 0, 0, 32'h3b39ffff,   0, 1, 25, 25, 32'hffffffff, 0, 0,  0};
    vecs[7]  = '{0, 1, 0, 0, 0, 32'h0,          1, 8, 0, 0, 32'h01095020,   1, 0, 0, 0, 32'h0,         0,  0,  1};
    vecs[8]  = '{0, 1, 0, 0, 0, 32'h0,          0, 8, 0, 0, 32'h01095020,   0, 1, 8, 9, 32'h5020,      5,  0,  1};
    vecs[9]  = '{0, 1, 0, 0, 0, 32'h0,          1, 8, 1, 0, 32'h01095020,   0, 0, 0, 0, 32'h0,         0,  0,  1};
    vecs[10] = '{0, 1, 0, 0, 0, 32'h0,          0, 0, 0, 0, 32'h20080005,   0, 1, 0, 8, 32'h5,         0,  5,  1};
    vecs[11] = '{0, 1, 0, 0, 0, 32'h0,          0, 0, 1, 1, 32'h3b39ffff,   0, 1, 0, 8, 32'h5,         0,  5,  1};
    vecs[12] = '{1, 1, 0, 0, 0, 32'h0,          1, 8, 0, 0, 32'h01095020,   1, 0, 0, 0, 32'h0,         0,  0,  0};
    vecs[13] = '{0, 1, 0, 0, 0, 32'h0,          0, 0, 0, 0, 32'h01095020,   0, 1, 8, 9, 32'h5020,      0,  0,  0};
    vecs[14] = '{0, 1, 0, 0, 0, 32'h0,          1, 9, 0, 0, 32'h01095020,   1, 0, 0, 0, 32'h0,         0,  0,  1};
    vecs[15] = '{0, 1, 0, 1, 9, 32'h1234,       0, 9, 0, 0, 32'h01095020,   0, 1, 8, 9, 32'h5020,      0,  32'h1234, 1};

    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i], 32'h0040_0000 + 32'(i * 4), st);
      check($sformatf("v%0d_stall", i), {31'h0, st},          {31'h0, vecs[i].exp_stall});
      check($sformatf("v%0d_valid", i), {31'h0, Valid_q},     {31'h0, vecs[i].exp_valid});
      check($sformatf("v%0d_rs", i),    {27'h0, Rs_q},        {27'h0, vecs[i].exp_rs});
      check($sformatf("v%0d_rt", i),    {27'h0, Rt_q},        {27'h0, vecs[i].exp_rt});
      check($sformatf("v%0d_imm", i),   Imm_q,                vecs[i].exp_imm);
      check($sformatf("v%0d_rd1", i),   ReadData1_q,          vecs[i].exp_rd1);
      check($sformatf("v%0d_rd2", i),   ReadData2_q,          vecs[i].exp_rd2);
      check($sformatf("v%0d_cnt", i),   {16'h0, StallCount},  32'(vecs[i].exp_cnt));
    end

    // Randomized traffic with specifiers kept small so hazards and bypasses recur.
    for (int i = 0; i < 400; i++) begin
      r = $urandom;
      v = vecs[0];
      v.rst   = ($urandom_range(0, 49) == 0);
      v.inval = ($urandom_range(0, 5) != 0);
      v.zext  = 1'($urandom_range(0, 1));
      v.rw    = 1'($urandom_range(0, 1));
      v.wr    = 5'($urandom_range(0, 9));
      v.wdata = $urandom;
      v.instr = r;
      v.instr[25:21] = 5'($urandom_range(0, 9));
      v.instr[20:16] = 5'($urandom_range(0, 9));
      v.exmr  = ($urandom_range(0, 2) == 0);
      v.exrt  = ($urandom_range(0, 1) == 1) ? v.instr[25:21] : 5'($urandom_range(0, 9));
      v.flush = ($urandom_range(0, 7) == 0);
      v.hold  = ($urandom_range(0, 7) == 0);
      applyStimulus(v, $urandom, st);
    end

    // Five back-to-back load-use stalls: narrow counter saturates at 3.
    applyStimulus(vecs[0], 32'h0, st);
    v = vecs[0];
    v.rst = 1'b0; v.inval = 1'b1; v.exmr = 1'b1; v.exrt = 5'd1; v.instr = 32'h00220000;
    for (int i = 0; i < 5; i++) applyStimulus(v, 32'h100, st);
    check("sat_cnt_wide",   {16'h0, StallCount}, 32'd5);
    check("sat_cnt_narrow", {30'h0, s_cnt},      32'd3);
    check("sat_valid",      {31'h0, Valid_q},    32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
